pc_fetch_unit: RTL and testbench

Parametrised fetch-stage program counter with redirect priority, stall hold and an optional direct-mapped branch target buffer (BTB) using 2-bit saturating counters. It sits at the front of the pipeline. Each cycle it produces the fetch PC and its +4 successor, plus a taken prediction and predicted target. It accepts resolved-branch redirects and BTB training from the execute stage.

---
 rtl/pc_fetch_if.sv | 28 ++
 rtl/pc_fetch_unit.sv | 124 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_if.sv
// Fetch-stage handshake bundle: execute-stage redirect/training inputs and fetch PC/prediction outputs.
interface pc_fetch_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  stallF;
  logic                  redirect_valid_E;
  logic [DATA_WIDTH-1:0] redirect_pc_E;
  logic                  btb_upd_valid_E;
  logic [DATA_WIDTH-1:0] btb_upd_pc_E;
  logic [DATA_WIDTH-1:0] btb_upd_target_E;
  logic                  btb_upd_taken_E;
  logic [DATA_WIDTH-1:0] pcF;
  logic [DATA_WIDTH-1:0] pcPlus4F;
  logic                  predTakenF;
  logic [DATA_WIDTH-1:0] predTargetF;

  modport master (
    output stallF, redirect_valid_E, redirect_pc_E,
    output btb_upd_valid_E, btb_upd_pc_E, btb_upd_target_E, btb_upd_taken_E,
    input  pcF, pcPlus4F, predTakenF, predTargetF
  );

  modport slave (
    input  stallF, redirect_valid_E, redirect_pc_E,
    input  btb_upd_valid_E, btb_upd_pc_E, btb_upd_target_E, btb_upd_taken_E,
    output pcF, pcPlus4F, predTakenF, predTargetF
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Fetch PC register with redirect > stall > predict > +4 priority.
// Direct-mapped BTB with 2-bit counters is built only when PC_FETCH_BTB_EN is defined.
module pc_fetch_unit #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    BTB_ENTRIES  = 16
) (
  input  logic        clk,
  input  logic        rst,
  pc_fetch_if.slave   bus
);
  localparam logic [DATA_WIDTH-1:0] RESET_PC = {RESET_VECTOR[DATA_WIDTH-1:2], 2'b00};

  logic [DATA_WIDTH-1:0] pc_reg;
  logic [DATA_WIDTH-1:0] pc_next;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic                  pred_taken;
  logic [DATA_WIDTH-1:0] pred_target;

  assign pc_plus4 = pc_reg + DATA_WIDTH'(4);

`ifdef PC_FETCH_BTB_EN
  localparam int IW = $clog2(BTB_ENTRIES);
  localparam int TW = DATA_WIDTH - IW - 2;

  logic [BTB_ENTRIES-1:0] valid_vec;
  logic [1:0]             ctr_arr    [BTB_ENTRIES];
  logic [TW-1:0]          tag_arr    [BTB_ENTRIES];
  logic [DATA_WIDTH-1:0]  target_arr [BTB_ENTRIES];

  logic [IW-1:0]         rd_idx;
  logic [TW-1:0]         rd_tag;
  logic                  rd_hit;
  logic [IW-1:0]         upd_idx;
  logic [TW-1:0]         upd_tag;
  logic                  upd_hit;
  logic [DATA_WIDTH-1:0] upd_target;
  logic                  unused_bits;

  assign rd_idx      = pc_reg[IW+1:2];
  assign rd_tag      = pc_reg[DATA_WIDTH-1:IW+2];
  assign rd_hit      = valid_vec[rd_idx] && (tag_arr[rd_idx] == rd_tag);
  assign pred_taken  = rd_hit && ctr_arr[rd_idx][1];
  assign pred_target = pred_taken ? target_arr[rd_idx] : pc_plus4;

  assign upd_idx     = bus.btb_upd_pc_E[IW+1:2];
  assign upd_tag     = bus.btb_upd_pc_E[DATA_WIDTH-1:IW+2];
  assign upd_hit     = valid_vec[upd_idx] && (tag_arr[upd_idx] == upd_tag);
  // Targets are stored word-aligned so a predicted PC can never carry low bits.
  assign upd_target  = {bus.btb_upd_target_E[DATA_WIDTH-1:2], 2'b00};
  assign unused_bits = ^{bus.btb_upd_pc_E[1:0], bus.btb_upd_target_E[1:0]};

  genvar gi;
  for (gi = 0; gi < BTB_ENTRIES; gi = gi + 1) begin : g_entry
    logic                  valid_reg;
    logic [1:0]            ctr_reg;
    logic [TW-1:0]         tag_reg;
    logic [DATA_WIDTH-1:0] target_reg;
    logic                  sel;

    assign sel = bus.btb_upd_valid_E && (upd_idx == IW'(gi));

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_reg <= 1'b0;
        ctr_reg   <= 2'b00;
      end else if (sel) begin
        if (upd_hit) begin
          if (bus.btb_upd_taken_E)
            ctr_reg <= (ctr_reg == 2'b11) ? 2'b11 : ctr_reg + 2'b01;
          else
            ctr_reg <= (ctr_reg == 2'b00) ? 2'b00 : ctr_reg - 2'b01;
        end else if (bus.btb_upd_taken_E) begin
          valid_reg <= 1'b1;
          ctr_reg   <= 2'b10;
        end
      end
    end

    // Tag/target need no reset; valid gates them. A taken hit rewrites the same tag.
    always_ff @(posedge clk) begin
      if (!rst && sel && bus.btb_upd_taken_E) begin
        tag_reg    <= upd_tag;
        target_reg <= upd_target;
      end
    end

    assign valid_vec[gi]  = valid_reg;
    assign ctr_arr[gi]    = ctr_reg;
    assign tag_arr[gi]    = tag_reg;
    assign target_arr[gi] = target_reg;
  end
`else
  logic unused_btb;

  assign pred_taken  = 1'b0;
  assign pred_target = pc_plus4;
  assign unused_btb  = ^{bus.btb_upd_valid_E, bus.btb_upd_pc_E,
                         bus.btb_upd_target_E, bus.btb_upd_taken_E};
`endif

  logic unused_redirect_bits;
  assign unused_redirect_bits = ^bus.redirect_pc_E[1:0];

  always_comb begin
    pc_next = pred_target;
    if (bus.redirect_valid_E)
      pc_next = {bus.redirect_pc_E[DATA_WIDTH-1:2], 2'b00};
    else if (bus.stallF)
      pc_next = pc_reg;
  end

  always_ff @(posedge clk) begin
    if (rst)
      pc_reg <= RESET_PC;
    else
      pc_reg <= pc_next;
  end

  assign bus.pcF         = pc_reg;
  assign bus.pcPlus4F    = pc_plus4;
  assign bus.predTakenF  = pred_taken;
  assign bus.predTargetF = pred_target;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit; BTB-dependent expectations follow PC_FETCH_BTB_EN.
module tb_pc_fetch_unit;
  localparam int DW = 32;

`ifdef PC_FETCH_BTB_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  pc_fetch_if #(.DATA_WIDTH(DW)) bus ();

  pc_fetch_unit #(
    .DATA_WIDTH  (DW),
    .RESET_VECTOR(32'h0),
    .BTB_ENTRIES (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
    $display("[TB] %-14s observed %h expected %h", tag, got, exp);
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
    $display("[TB] %-14s observed %b expected %b", tag, got, exp);
  endtask

  task automatic redirect(input logic [DW-1:0] pc);
    bus.redirect_valid_E = 1'b1;
    bus.redirect_pc_E    = pc;
    tick();
    bus.redirect_valid_E = 1'b0;
  endtask

  task automatic train(input logic [DW-1:0] pc, input logic [DW-1:0] tgt, input logic taken);
    bus.btb_upd_valid_E  = 1'b1;
    bus.btb_upd_pc_E     = pc;
    bus.btb_upd_target_E = tgt;
    bus.btb_upd_taken_E  = taken;
    tick();
    bus.btb_upd_valid_E  = 1'b0;
  endtask

  initial begin
    bus.stallF           = 1'b0;
    bus.redirect_valid_E = 1'b0;
    bus.redirect_pc_E    = '0;
    bus.btb_upd_valid_E  = 1'b0;
    bus.btb_upd_pc_E     = '0;
    bus.btb_upd_target_E = '0;
    bus.btb_upd_taken_E  = 1'b0;

    // Reset state and free running
    tick(); tick();
    rst = 1'b0;
    chk32("rst_pc",      bus.pcF,         32'h0);
    chk32("rst_plus4",   bus.pcPlus4F,    32'h4);
    chk1 ("rst_taken",   bus.predTakenF,  1'b0);
    chk32("rst_target",  bus.predTargetF, 32'h4);
    tick(); chk32("run_pc4", bus.pcF, 32'h4);
    tick(); chk32("run_pc8", bus.pcF, 32'h8);
    tick(); chk32("run_pcC", bus.pcF, 32'hC);
    chk1("run_taken", bus.predTakenF, 1'b0);

    // Stall and redirect overriding stall
    redirect(32'h8);
    chk32("redir_8", bus.pcF, 32'h8);
    bus.stallF = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk32("stall_hold", bus.pcF, 32'h8);
    end
    redirect(32'h103);
    bus.stallF = 1'b0;
    chk32("redir_stall", bus.pcF, 32'h100);

    // Train taken, then predict
    train(32'h10, 32'h40, 1'b1);
    chk32("train_adv", bus.pcF, 32'h104);
    redirect(32'h10);
    chk1 ("pred_taken", bus.predTakenF,  BTB);
    chk32("pred_tgt",   bus.predTargetF, BTB ? 32'h40 : 32'h14);
    tick();
    chk32("pred_follow", bus.pcF, BTB ? 32'h40 : 32'h14);

    // Hysteresis: 10 -> 01 -> 00, then taken -> 01
    train(32'h10, 32'h40, 1'b0);
    train(32'h10, 32'h40, 1'b0);
    redirect(32'h10);
    chk1("hyst_nt", bus.predTakenF, 1'b0);
    tick();
    chk32("hyst_next", bus.pcF, 32'h14);
    train(32'h10, 32'h40, 1'b1);
    redirect(32'h10);
    chk1("hyst_01", bus.predTakenF, 1'b0);
    // Same-cycle training at the looked-up index: lookup sees old contents
    bus.btb_upd_valid_E  = 1'b1;
    bus.btb_upd_pc_E     = 32'h10;
    bus.btb_upd_target_E = 32'h60;
    bus.btb_upd_taken_E  = 1'b1;
    #1;
    chk1("same_cyc_old", bus.predTakenF, 1'b0);
    tick();
    bus.btb_upd_valid_E = 1'b0;
    chk32("same_cyc_next", bus.pcF, 32'h14);
    redirect(32'h10);
    chk1 ("ctr10_taken", bus.predTakenF,  BTB);
    chk32("tgt_overwr",  bus.predTargetF, BTB ? 32'h60 : 32'h14);

    // Aliasing: 0x50 shares index 4 with 0x10
    redirect(32'h50);
    chk1 ("alias_miss", bus.predTakenF,  1'b0);
    chk32("alias_tgt",  bus.predTargetF, 32'h54);
    train(32'h50, 32'h80, 1'b1);
    chk32("alias_adv", bus.pcF, 32'h54);
    redirect(32'h10);
    chk1("alias_old", bus.predTakenF, 1'b0);
    redirect(32'h50);
    chk1 ("alias_new",   bus.predTakenF,  BTB);
    chk32("alias_ntgt",  bus.predTargetF, BTB ? 32'h80 : 32'h54);
    tick();
    chk32("alias_follow", bus.pcF, BTB ? 32'h80 : 32'h54);

    // Wrap-around
    redirect(32'hFFFF_FFFC);
    chk32("wrap_pc",    bus.pcF,      32'hFFFF_FFFC);
    chk32("wrap_plus4", bus.pcPlus4F, 32'h0);
    tick();
    chk32("wrap_zero", bus.pcF, 32'h0);

    // Reset mid-stream beats stall, redirect and training
    redirect(32'h50);
    rst                  = 1'b1;
    bus.stallF           = 1'b1;
    bus.redirect_valid_E = 1'b1;
    bus.redirect_pc_E    = 32'h200;
    bus.btb_upd_valid_E  = 1'b1;
    bus.btb_upd_pc_E     = 32'h30;
    bus.btb_upd_target_E = 32'h90;
    bus.btb_upd_taken_E  = 1'b1;
    tick();
    rst                  = 1'b0;
    bus.stallF           = 1'b0;
    bus.redirect_valid_E = 1'b0;
    bus.btb_upd_valid_E  = 1'b0;
    chk32("mid_rst_pc", bus.pcF, 32'h0);
    redirect(32'h50);
    chk1("rst_clr_50", bus.predTakenF, 1'b0);
    redirect(32'h30);
    chk1("rst_clr_30", bus.predTakenF, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
